// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder
// Packs decoded instruction fields back into 32-bit RV64 instruction words (inverse of the
// decode-stage immediate extender) and emits them with a sequential byte address.
// Supported formats: I-load (0000011), I-ALU (0010011), S (0100011), SB (1100011), R (0110011).
// Out-of-range immediates and unsupported opcodes are flagged, counted and, when STOP_ON_ERR
// is set, drive the block into a HALT state that only reset leaves.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready depends on out_ready, never on in_valid
//   opcode, rd, rs1, rs2  decoded fields
//   funct3, funct7
//   imm                   64-bit signed immediate in decoder units (SB = halfword offset)
//   out_valid/out_ready   output handshake
//   out_instr, out_addr   encoded word and its instruction-memory byte address
//   out_err               presented word is erroneous
//   err_count             saturating count of erroneous words accepted
//   halted                block is in HALT
module imm_instr_encoder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [63:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       err_count,
  output logic              halted
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpAluImm = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [31:0]       NopInstr = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] AddrInit = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(4);
  localparam logic              StopOnErr = (STOP_ON_ERR != 0);

  typedef enum logic [1:0] {StEmpty, StFull, StHalt} state_e;

  state_e             state_q;
  logic               out_valid_q;
  logic [31:0]        out_instr_q;
  logic [ADDR_W-1:0]  out_addr_q;
  logic               out_err_q;
  logic [15:0]        err_count_q;

  logic        imm_oor;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        accept;
  logic        out_hs;

  // The immediate must be representable as a 12-bit signed field: every bit above bit 11
  // has to be a copy of bit 11.
  assign imm_oor = (imm[63:11] != {53{imm[11]}});

  always_comb begin
    enc_instr = NopInstr;
    enc_err   = 1'b1;
    case (opcode)
      OpLoad, OpAluImm: begin
        enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err   = imm_oor;
      end
      OpStore: begin
        enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err   = imm_oor;
      end
      OpBranch: begin
        // imm is already a halfword offset, so imm[11:0] maps to branch offset bits 12:1.
        enc_instr = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
        enc_err   = imm_oor;
      end
      OpReg: begin
        enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err   = 1'b0;
      end
      default: begin
        enc_instr = NopInstr;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Gated by reset so the block advertises nothing during the reset cycle.
  assign in_ready = ~reset & ((state_q == StEmpty) | ((state_q == StFull) & out_ready));
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= AddrInit;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (out_hs) begin
        out_addr_q <= out_addr_q + AddrStep;
      end

      if (accept) begin
        out_valid_q <= 1'b1;
        out_instr_q <= enc_instr;
        out_err_q   <= enc_err;
        if (enc_err && (err_count_q != 16'hFFFF)) begin
          err_count_q <= err_count_q + 16'd1;
        end
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        StEmpty, StFull: begin
          if (accept) begin
            state_q <= (enc_err && StopOnErr) ? StHalt : StFull;
          end else if (out_hs) begin
            state_q <= StEmpty;
          end
        end
        // HALT keeps presenting the last word until it is taken; out_valid_q handles that.
        StHalt:  state_q <= StHalt;
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;
  assign halted    = (state_q == StHalt);

endmodule
